// File: rtl/fsic_pkg.sv
// Shared types and defaults for the FSIC config-port arbiter.
// State encoding, requester ids and timeout defaults.
package fsic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic ID_WB  = 1'b0;
  localparam logic ID_RMT = 1'b1;

  localparam int          DEF_TIMEOUT_CYC = 255;
  localparam logic [31:0] DEF_TO_RDATA    = 32'hFFFF_FFFF;
  localparam logic [7:0]  TO_CNT_MAX      = 8'hFF;

endpackage

// File: rtl/fsic_rr_arb2.sv
// Two-input round-robin grant with a last-grant register.
// Ties go to the requester not granted last.
module fsic_rr_arb2
  import fsic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_q;
  logic last_d;

  // Pick a winner; remember it only when the grant is taken
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last_q : req1;
    last_d    = last_q;
    if (en && gnt_valid) begin
      last_d = gnt_id;
    end
  end

  // Last-grant register, resets so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= ID_RMT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fsic_cfg_arb.sv
// Arbiter between the mgmt Wishbone port and the remote port
// for a single shared config-register target, with timeout.
module fsic_cfg_arb
  import fsic_pkg::*;
#(
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [31:0] TO_RDATA    = DEF_TO_RDATA
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic [31:0] wbs_adr,
  input  logic [31:0] wbs_wdata,
  input  logic [3:0]  wbs_sel,
  output logic        wbs_ack,
  output logic [31:0] wbs_rdata,
  input  logic        rreq_valid,
  output logic        rreq_ready,
  input  logic        rreq_we,
  input  logic [31:0] rreq_adr,
  input  logic [31:0] rreq_wdata,
  input  logic [3:0]  rreq_sel,
  output logic        rrsp_valid,
  input  logic        rrsp_ready,
  output logic [31:0] rrsp_rdata,
  output logic        rrsp_err,
  output logic        cfg_req,
  output logic        cfg_we,
  output logic [31:0] cfg_adr,
  output logic [31:0] cfg_wdata,
  output logic [3:0]  cfg_sel,
  input  logic        cfg_ack,
  input  logic [31:0] cfg_rdata,
  output logic [7:0]  to_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          live_q, live_d;
  logic          fresh_q, fresh_d;

  logic take;
  logic gnt_valid;
  logic gnt_id;
  logic busy;
  logic resp;

  // A new grant is only taken in a settled IDLE cycle out of reset
  assign take = wb_rst_n & (state_q == ST_IDLE) & ~fresh_q;

  fsic_rr_arb2 u_arb (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .en        (take),
    .req0      (wbs_cyc & wbs_stb),
    .req1      (rreq_valid),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next-state and datapath for the single in-flight access
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    live_d   = live_q;
    fresh_d  = fresh_q;
    unique case (state_q)
      ST_IDLE: begin
        fresh_d = 1'b0;
        if (take && gnt_valid) begin
          id_d    = gnt_id;
          timer_d = '0;
          state_d = ST_BUSY;
          if (gnt_id == ID_WB) begin
            we_d    = wbs_we;
            adr_d   = wbs_adr;
            wdata_d = wbs_wdata;
            sel_d   = wbs_sel;
            live_d  = 1'b1;
          end else begin
            we_d    = rreq_we;
            adr_d   = rreq_adr;
            wdata_d = rreq_wdata;
            sel_d   = rreq_sel;
            live_d  = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (id_q == ID_WB && !wbs_cyc) begin
          live_d = 1'b0;
        end
        if (cfg_ack) begin
          rdata_d = we_q ? 32'h0 : cfg_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TLAST) begin
          rdata_d = TO_RDATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (to_cnt_q != TO_CNT_MAX) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (id_q == ID_WB || rrsp_ready) begin
          state_d = ST_IDLE;
          fresh_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and access registers
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= ID_WB;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      live_q   <= 1'b0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
      live_q   <= live_d;
      fresh_q  <= fresh_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign resp = (state_q == ST_RESP);

  // Target port is quiet (all zero) outside BUSY
  assign cfg_req   = busy;
  assign cfg_we    = busy & we_q;
  assign cfg_adr   = busy ? adr_q : '0;
  assign cfg_wdata = busy ? wdata_q : '0;
  assign cfg_sel   = busy ? sel_q : '0;

  assign wbs_ack   = resp & (id_q == ID_WB) & live_q;
  assign wbs_rdata = wbs_ack ? rdata_q : '0;

  assign rreq_ready = take & gnt_valid & (gnt_id == ID_RMT);
  assign rrsp_valid = resp & (id_q == ID_RMT);
  assign rrsp_rdata = rrsp_valid ? rdata_q : '0;
  assign rrsp_err   = rrsp_valid & err_q;

  assign to_cnt = to_cnt_q;

endmodule

// File: tb/tb_fsic_cfg_arb.sv
// Directed bench for fsic_cfg_arb.
// Inputs change 1 ns after rising edge; outputs sampled 4 ns after.
module tb_fsic_cfg_arb;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [31:0] wbs_adr, wbs_wdata;
  logic [3:0]  wbs_sel;
  logic        wbs_ack;
  logic [31:0] wbs_rdata;
  logic        rreq_valid, rreq_ready, rreq_we;
  logic [31:0] rreq_adr, rreq_wdata;
  logic [3:0]  rreq_sel;
  logic        rrsp_valid, rrsp_ready;
  logic [31:0] rrsp_rdata;
  logic        rrsp_err;
  logic        cfg_req, cfg_we;
  logic [31:0] cfg_adr, cfg_wdata;
  logic [3:0]  cfg_sel;
  logic        cfg_ack;
  logic [31:0] cfg_rdata;
  logic [7:0]  to_cnt;

  int total = 0;
  int bad = 0;
  int n;

  always #5 wb_clk = ~wb_clk;

  fsic_cfg_arb dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .wbs_cyc    (wbs_cyc),
    .wbs_stb    (wbs_stb),
    .wbs_we     (wbs_we),
    .wbs_adr    (wbs_adr),
    .wbs_wdata  (wbs_wdata),
    .wbs_sel    (wbs_sel),
    .wbs_ack    (wbs_ack),
    .wbs_rdata  (wbs_rdata),
    .rreq_valid (rreq_valid),
    .rreq_ready (rreq_ready),
    .rreq_we    (rreq_we),
    .rreq_adr   (rreq_adr),
    .rreq_wdata (rreq_wdata),
    .rreq_sel   (rreq_sel),
    .rrsp_valid (rrsp_valid),
    .rrsp_ready (rrsp_ready),
    .rrsp_rdata (rrsp_rdata),
    .rrsp_err   (rrsp_err),
    .cfg_req    (cfg_req),
    .cfg_we     (cfg_we),
    .cfg_adr    (cfg_adr),
    .cfg_wdata  (cfg_wdata),
    .cfg_sel    (cfg_sel),
    .cfg_ack    (cfg_ack),
    .cfg_rdata  (cfg_rdata),
    .to_cnt     (to_cnt)
  );

  task automatic nx();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_go(input logic we, input logic [31:0] adr,
                       input logic [31:0] wd);
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    wbs_we = we;
    wbs_adr = adr;
    wbs_wdata = wd;
    wbs_sel = 4'hF;
  endtask

  task automatic wb_stop();
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    wbs_adr = 0; wbs_wdata = 0; wbs_sel = 0;
    rreq_valid = 1'b1; rreq_we = 0;
    rreq_adr = 0; rreq_wdata = 0; rreq_sel = 0;
    rrsp_ready = 0; cfg_ack = 0; cfg_rdata = 0;

    // reset state
    nx(); nx(); #3;
    chk("rst_cfg_req", cfg_req, 0);
    chk("rst_rreq_ready", rreq_ready, 0);
    chk("rst_wbs_ack", wbs_ack, 0);
    chk("rst_wbs_rdata", wbs_rdata, 0);
    chk("rst_rrsp_valid", rrsp_valid, 0);
    chk("rst_rrsp_rdata", rrsp_rdata, 0);
    chk("rst_cfg_adr", cfg_adr, 0);
    chk("rst_to_cnt", to_cnt, 0);
    rreq_valid = 1'b0;
    nx(); wb_rst_n = 1'b1;

    // three ties: WB, remote, WB
    nx();
    wb_go(1'b1, 32'h100, 32'hAAAA);
    rreq_valid = 1'b1; rreq_we = 1'b1;
    rreq_adr = 32'h200; rreq_wdata = 32'h55; rreq_sel = 4'h3;
    #3;
    chk("tie1_rdy", rreq_ready, 0);
    chk("tie1_req_idle", cfg_req, 0);
    nx(); cfg_ack = 1'b1; cfg_rdata = 32'h1111; #3;
    chk("tie1_req", cfg_req, 1);
    chk("tie1_adr", cfg_adr, 32'h100);
    chk("tie1_we", cfg_we, 1);
    chk("tie1_wdata", cfg_wdata, 32'hAAAA);
    nx(); cfg_ack = 1'b0; #3;
    chk("tie1_ack", wbs_ack, 1);
    chk("tie1_wr_rdata", wbs_rdata, 0);
    chk("tie1_req_off", cfg_req, 0);
    nx(); wb_stop(); #3;
    chk("fresh1_rdy", rreq_ready, 0);
    chk("fresh1_ack", wbs_ack, 0);
    nx(); wb_go(1'b0, 32'h104, 32'h0); #3;
    chk("tie2_rdy", rreq_ready, 1);
    nx(); rreq_valid = 1'b0; cfg_ack = 1'b1; cfg_rdata = 32'h99; #3;
    chk("tie2_adr", cfg_adr, 32'h200);
    chk("tie2_wdata", cfg_wdata, 32'h55);
    chk("tie2_sel", cfg_sel, 4'h3);
    chk("tie2_rdy_off", rreq_ready, 0);
    nx(); cfg_ack = 1'b0; rrsp_ready = 1'b1; #3;
    chk("tie2_rsp_valid", rrsp_valid, 1);
    chk("tie2_wr_rdata", rrsp_rdata, 0);
    chk("tie2_err", rrsp_err, 0);
    chk("tie2_no_wback", wbs_ack, 0);
    nx(); rrsp_ready = 1'b0;
    rreq_valid = 1'b1; rreq_we = 1'b1;
    rreq_adr = 32'h208; rreq_wdata = 32'h5A5A;
    #3;
    chk("fresh2_valid", rrsp_valid, 0);
    chk("fresh2_rdy", rreq_ready, 0);
    chk("fresh2_req", cfg_req, 0);
    nx(); #3;
    chk("tie3_rdy", rreq_ready, 0);
    nx(); cfg_ack = 1'b1; cfg_rdata = 32'h77; #3;
    chk("tie3_adr", cfg_adr, 32'h104);
    chk("tie3_we", cfg_we, 0);
    nx(); cfg_ack = 1'b0; #3;
    chk("tie3_ack", wbs_ack, 1);
    chk("tie3_rdata", wbs_rdata, 32'h77);
    nx(); wb_stop(); #3;
    chk("fresh3_rdy", rreq_ready, 0);
    nx(); #3;
    chk("rmt_rdy", rreq_ready, 1);

    // remote write that never gets acked
    nx(); rreq_valid = 1'b0; #3;
    chk("to_adr", cfg_adr, 32'h208);
    chk("to_wdata", cfg_wdata, 32'h5A5A);
    n = 0;
    while (cfg_req === 1'b1 && n < 400) begin
      n++;
      nx(); #3;
    end
    chk("to_req_cycles", n, 255);
    chk("to_valid", rrsp_valid, 1);
    chk("to_err", rrsp_err, 1);
    chk("to_rdata", rrsp_rdata, 32'hFFFF_FFFF);
    chk("to_cnt", to_cnt, 1);

    // back-pressure with a WB request waiting
    wb_go(1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 10; i++) begin
      nx(); #3;
      chk("bp_valid", rrsp_valid, 1);
      chk("bp_rdata", rrsp_rdata, 32'hFFFF_FFFF);
      chk("bp_no_req", cfg_req, 0);
    end
    rrsp_ready = 1'b1; #1;
    chk("bp_accept_valid", rrsp_valid, 1);
    nx(); rrsp_ready = 1'b0; #3;
    chk("bp_done_valid", rrsp_valid, 0);
    chk("bp_fresh_req", cfg_req, 0);
    nx(); #3;
    chk("bp_grant_req", cfg_req, 0);

    // reset during BUSY
    nx(); wb_rst_n = 1'b0; wb_stop(); #3;
    chk("rb_busy_req", cfg_req, 1);
    chk("rb_busy_adr", cfg_adr, 32'h300);
    nx(); #3;
    chk("rb_req", cfg_req, 0);
    chk("rb_adr", cfg_adr, 0);
    chk("rb_ack", wbs_ack, 0);
    chk("rb_rvalid", rrsp_valid, 0);
    chk("rb_to_cnt", to_cnt, 0);
    nx(); wb_rst_n = 1'b1;

    // WB read, ack one cycle after cfg_req
    nx(); wb_go(1'b0, 32'h3000_0010, 32'h0); #3;
    chk("rd_n_req", cfg_req, 0);
    nx(); #3;
    chk("rd_n1_req", cfg_req, 1);
    chk("rd_n1_adr", cfg_adr, 32'h3000_0010);
    nx(); cfg_ack = 1'b1; cfg_rdata = 32'h1234_5678; #3;
    chk("rd_n2_ack", wbs_ack, 0);
    nx(); cfg_ack = 1'b0; #3;
    chk("rd_n3_ack", wbs_ack, 1);
    chk("rd_n3_rdata", wbs_rdata, 32'h1234_5678);
    chk("rd_n3_req", cfg_req, 0);
    nx(); wb_stop(); #3;
    chk("rd_n4_ack", wbs_ack, 0);
    chk("rd_n4_rdata", wbs_rdata, 0);

    // WB abandons the cycle during BUSY
    nx(); wb_go(1'b0, 32'h40, 32'h0); #3;
    nx(); wb_stop(); #3;
    chk("ab_req", cfg_req, 1);
    chk("ab_adr", cfg_adr, 32'h40);
    nx(); cfg_ack = 1'b1; cfg_rdata = 32'hDEAD; #3;
    chk("ab_req_wait", cfg_req, 1);
    nx(); cfg_ack = 1'b0; #3;
    chk("ab_no_ack", wbs_ack, 0);
    chk("ab_rdata", wbs_rdata, 0);
    chk("ab_req_off", cfg_req, 0);
    nx(); wb_go(1'b0, 32'h44, 32'h0); #3;
    chk("ab_fresh_req", cfg_req, 0);
    nx(); #3;
    chk("ab_grant_req", cfg_req, 0);
    nx(); cfg_ack = 1'b1; cfg_rdata = 32'hBEEF; #3;
    chk("ab_next_req", cfg_req, 1);
    chk("ab_next_adr", cfg_adr, 32'h44);
    nx(); cfg_ack = 1'b0; #3;
    chk("ab_next_ack", wbs_ack, 1);
    chk("ab_next_rdata", wbs_rdata, 32'hBEEF);
    nx(); wb_stop(); #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
